// File: rtl/rtc_bcd_counter_if.sv
// rtc_bcd_counter_if: bundles the tick, time-set and time-output signals of
// rtc_bcd_counter so the counter and its user connect through one port.
//
// Signals:
//   tick_i       divided square wave; its rising edge is the one-second event
//   set_en_i     level, 1 = set mode (counting frozen)
//   set_field_i  field select: 0 = sec, 1 = min, 2 = hour, 3 = none
//   set_inc_i    single-cycle increment pulse for the selected field
//   hour_o       BCD hours 00..23
//   min_o        BCD minutes 00..59
//   sec_o        BCD seconds 00..59
//   sec_pulse_o  1-cycle pulse on every seconds advance
//   day_wrap_o   1-cycle pulse on 23:59:59 -> 00:00:00
//   alarm_hh_i, alarm_mm_i, alarm_arm_i, alarm_o exist only when RTC_ALARM_EN
//   is defined.
//
// Modports: master drives the inputs and reads the time; slave is the counter.

interface rtc_bcd_counter_if;

   logic       tick_i;
   logic       set_en_i;
   logic [1:0] set_field_i;
   logic       set_inc_i;
   logic [7:0] hour_o;
   logic [7:0] min_o;
   logic [7:0] sec_o;
   logic       sec_pulse_o;
   logic       day_wrap_o;

`ifdef RTC_ALARM_EN
   logic [7:0] alarm_hh_i;
   logic [7:0] alarm_mm_i;
   logic       alarm_arm_i;
   logic       alarm_o;

   modport master (
      output tick_i, set_en_i, set_field_i, set_inc_i,
      output alarm_hh_i, alarm_mm_i, alarm_arm_i,
      input  hour_o, min_o, sec_o, sec_pulse_o, day_wrap_o, alarm_o
   );

   modport slave (
      input  tick_i, set_en_i, set_field_i, set_inc_i,
      input  alarm_hh_i, alarm_mm_i, alarm_arm_i,
      output hour_o, min_o, sec_o, sec_pulse_o, day_wrap_o, alarm_o
   );
`else
   modport master (
      output tick_i, set_en_i, set_field_i, set_inc_i,
      input  hour_o, min_o, sec_o, sec_pulse_o, day_wrap_o
   );

   modport slave (
      input  tick_i, set_en_i, set_field_i, set_inc_i,
      output hour_o, min_o, sec_o, sec_pulse_o, day_wrap_o
   );
`endif

endinterface

// File: rtl/rtc_bcd_counter.sv
// rtc_bcd_counter: 24-hour BCD HH:MM:SS time-of-day counter. Each rising edge
// of the (synchronised) tick_i square wave advances the time by one second,
// with all carries resolved in one cycle. Set mode freezes counting and lets
// upstream-debounced pulses step a single field with in-field wrap.
//
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  rtc_bcd_counter_if.slave: tick/set inputs, BCD time and pulse outputs
//
// Parameters:
//   SYNC_STAGES  flops in the tick_i synchroniser (>= 2)
//   INIT_HH/MM/SS  BCD time loaded on reset
//
// Optional feature: define RTC_ALARM_EN to add the alarm compare and alarm_o.

module rtc_bcd_counter #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  INIT_HH     = 8'h00,
   parameter logic [7:0]  INIT_MM     = 8'h00,
   parameter logic [7:0]  INIT_SS     = 8'h00
) (
   input logic               clk,
   input logic               rst,
   rtc_bcd_counter_if.slave  bus
);

   // Returns {wrapped, next} for a BCD pair counting 00..max.
   function automatic logic [8:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
      logic [8:0] res;
      if (val == max) begin
         res = {1'b1, 8'h00};
      end else if (val[3:0] == 4'h9) begin
         res = {1'b0, val[7:4] + 4'h1, 4'h0};
      end else begin
         res = {1'b0, val[7:4], val[3:0] + 4'h1};
      end
      return res;
   endfunction

   // Tick synchroniser and rising-edge detect
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_last;
   logic                   edge_q;
   logic                   tick_evt;

   assign sync_last = sync_q[SYNC_STAGES-1];
   assign tick_evt  = sync_last & ~edge_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.tick_i};
         edge_q <= sync_last;
      end
   end

   // Time registers
   logic [7:0] hour_q, hour_d;
   logic [7:0] min_q, min_d;
   logic [7:0] sec_q, sec_d;
   logic       sec_pulse_q, sec_pulse_d;
   logic       day_wrap_q, day_wrap_d;

   logic [8:0] sec_inc, min_inc, hour_inc;

   assign sec_inc  = bcd_inc(sec_q, 8'h59);
   assign min_inc  = bcd_inc(min_q, 8'h59);
   assign hour_inc = bcd_inc(hour_q, 8'h23);

   always_comb begin
      hour_d      = hour_q;
      min_d       = min_q;
      sec_d       = sec_q;
      sec_pulse_d = 1'b0;
      day_wrap_d  = 1'b0;
      if (bus.set_en_i) begin
         // Set mode swallows any tick edge; the synchroniser keeps running so
         // leaving set mode does not create a false edge.
         if (bus.set_inc_i) begin
            unique case (bus.set_field_i)
               2'd0: sec_d  = sec_inc[7:0];
               2'd1: min_d  = min_inc[7:0];
               2'd2: hour_d = hour_inc[7:0];
               2'd3: ;
            endcase
         end
      end else if (tick_evt) begin
         sec_pulse_d = 1'b1;
         sec_d       = sec_inc[7:0];
         if (sec_inc[8]) begin
            min_d = min_inc[7:0];
            if (min_inc[8]) begin
               hour_d     = hour_inc[7:0];
               day_wrap_d = hour_inc[8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hour_q      <= INIT_HH;
         min_q       <= INIT_MM;
         sec_q       <= INIT_SS;
         sec_pulse_q <= 1'b0;
         day_wrap_q  <= 1'b0;
      end else begin
         hour_q      <= hour_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         sec_pulse_q <= sec_pulse_d;
         day_wrap_q  <= day_wrap_d;
      end
   end

   assign bus.hour_o      = hour_q;
   assign bus.min_o       = min_q;
   assign bus.sec_o       = sec_q;
   assign bus.sec_pulse_o = sec_pulse_q;
   assign bus.day_wrap_o  = day_wrap_q;

`ifdef RTC_ALARM_EN
   logic alarm_q, alarm_d;

   // sec_pulse_q marks the cycle after a counted advance, so set-mode edits
   // can never raise the alarm.
   always_comb begin
      alarm_d = alarm_q;
      if (!bus.alarm_arm_i || (min_q != bus.alarm_mm_i)) begin
         alarm_d = 1'b0;
      end else if (sec_pulse_q && (hour_q == bus.alarm_hh_i) && (sec_q == 8'h00)) begin
         alarm_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alarm_q <= 1'b0;
      end else begin
         alarm_q <= alarm_d;
      end
   end

   assign bus.alarm_o = alarm_q;
`endif

endmodule
